// File: rtl/am2918_bus_sched_if.sv
// Bus-scheduler signal bundle between requesters, the scheduler and an am2918 register bank.
// Latency: none, wires only.
// Backpressure: none; req is level-sensitive and is held by the requester until it is served.
interface am2918_bus_sched_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ld;
    logic [N-1:0]  oe_;
    logic [IW-1:0] gidx;
    logic          busy;
    logic          done;

    modport master (
        input  req,
        output gnt, ld, oe_, gidx, busy, done
    );

    modport slave (
        output req,
        input  gnt, ld, oe_, gidx, busy, done
    );
endinterface

// File: rtl/am2918_bus_sched.sv
// Round-robin owner of a shared three-state bus: LOAD strobe, HOLD drive cycles, one dead TURN cycle.
// Latency: grant one cycle after the sampling edge; transaction and back-to-back period are HOLD+2 cycles.
// Backpressure: requests wait, level-held, until arbitration in IDLE/TURN picks them; in-flight grants never abort.
module am2918_bus_sched #(
    parameter int N    = 4,
    parameter int HOLD = 1,
    parameter int IW   = 2
) (
    input  logic               cp,
    input  logic               rst_,
    am2918_bus_sched_if.master bus
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic [IW:0]   scan;

    // Rotating priority search: first set request at or after ptr, modulo N.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        scan    = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (IW + 1)'(k);
            if (scan >= N_EXT) begin
                scan = scan - N_EXT;
            end
            if (!win_vld && bus.req[scan[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[IW-1:0];
            end
        end
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge cp) begin
        if (!rst_) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            bus.gnt  <= '0;
            bus.ld   <= '0;
            bus.oe_  <= '1;
            bus.gidx <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.ld   <= '0;
            bus.done <= 1'b0;
            case (state)
                S_IDLE, S_TURN: begin
                    bus.oe_ <= '1;
                    if (win_vld) begin
                        state    <= S_LOAD;
                        bus.gnt  <= win_oh;
                        bus.ld   <= win_oh;
                        bus.gidx <= win_idx;
                        bus.busy <= 1'b1;
                        ptr      <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state   <= S_DRIVE;
                    cnt     <= CNT_INIT;
                    bus.oe_ <= ~bus.gnt;
                end
                S_DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Release the driver now so TURN is a guaranteed dead bus cycle.
                        state    <= S_TURN;
                        bus.oe_  <= '1;
                        bus.gnt  <= '0;
                        bus.done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge cp) disable iff (!rst_) $onehot0(bus.gnt));
    a_oe_onehot:  assert property (@(posedge cp) disable iff (!rst_) $onehot0(~bus.oe_));
    a_ld_vs_oe:   assert property (@(posedge cp) disable iff (!rst_) (bus.ld & ~bus.oe_) == '0);
    a_oe_drive:   assert property (@(posedge cp) disable iff (!rst_) (state != S_DRIVE) |-> (&bus.oe_));
    a_busy:       assert property (@(posedge cp) disable iff (!rst_) bus.busy == (state != S_IDLE));
endmodule

// File: tb/tb_am2918_bus_sched.sv
// Scoreboarded bench: transaction-level round-robin model predicts grants, a negedge monitor checks every cycle.
// Latency: n/a. Backpressure: n/a.
// Stimulus covers directed scenarios, mid-transaction reset and randomized requests.
module tb_am2918_bus_sched;
    localparam int N    = 4;
    localparam int HOLD = 2;
    localparam int IW   = 2;

    logic cp = 1'b0;
    logic rst_;

    am2918_bus_sched_if #(.N(N), .IW(IW)) bus ();

    am2918_bus_sched #(.N(N), .HOLD(HOLD), .IW(IW)) dut (
        .cp   (cp),
        .rst_ (rst_),
        .bus  (bus.master)
    );

    always #5 cp = ~cp;

    int cyc = 0;
    always @(posedge cp) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int l;
    } txn_t;

    txn_t exp_q[$];
    int   m_ptr;
    int   t_arb;
    int   exp_gidx;
    bit   cur_vld;
    int   cur_idx;
    int   cur_l;
    bit   mon_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_low_cyc = -10;
    int   last_low_idx = -1;
    int   run_len      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Apply reset/request for the next edge and advance the transaction-level model.
    task automatic drive(input logic r, input logic [N-1:0] q);
        int e;
        bit found;
        int w;
        @(negedge cp);
        #1;
        rst_    = r;
        bus.req = q;
        e       = cyc + 1;
        if (!r) begin
            m_ptr    = 0;
            exp_q.delete();
            cur_vld  = 1'b0;
            exp_gidx = 0;
            t_arb    = e + 1;
        end else if (e == t_arb) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && q[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
            if (found) begin
                exp_q.push_back('{idx: w, l: e});
                m_ptr = (w + 1) % N;
                t_arb = e + HOLD + 2;
            end else begin
                t_arb = e + 1;
            end
        end
    endtask

    always @(negedge cp) begin
        if (mon_en) begin : mon
            logic [N-1:0] exp_ld;
            logic [N-1:0] oh;
            logic [N-1:0] exp_gnt;
            logic [N-1:0] exp_oe;
            bit in_l, in_d, in_t;
            int d;
            exp_ld = '0;
            if (exp_q.size() > 0 && exp_q[0].l == cyc) begin
                exp_ld[exp_q[0].idx] = 1'b1;
                cur_vld  = 1'b1;
                cur_idx  = exp_q[0].idx;
                cur_l    = cyc;
                exp_gidx = cur_idx;
                exp_q.delete(0);
            end
            chk("ld", bus.ld, exp_ld);
            in_l = cur_vld && (cyc == cur_l);
            in_d = cur_vld && (cyc > cur_l) && (cyc <= cur_l + HOLD);
            in_t = cur_vld && (cyc == cur_l + HOLD + 1);
            oh = '0;
            if (cur_vld) oh[cur_idx] = 1'b1;
            exp_gnt = (in_l || in_d) ? oh : '0;
            exp_oe  = in_d ? ~oh : '1;
            chk("gnt", bus.gnt, exp_gnt);
            chk("oe_", bus.oe_, exp_oe);
            chk("done", bus.done, in_t);
            chk("busy", bus.busy, in_l || in_d || in_t);
            chk("gidx", bus.gidx, exp_gidx);
            chk("oe_single_low", $countones(~bus.oe_) <= 1, 1);
            chk("ld_oe_overlap", |(bus.ld & ~bus.oe_), 0);
            d = -1;
            for (int k = 0; k < N; k++) begin
                if (!bus.oe_[k]) d = k;
            end
            if (d >= 0) begin
                if (last_low_cyc == cyc - 1 && d == last_low_idx) begin
                    run_len++;
                end else begin
                    chk("dead_cycle", last_low_cyc == cyc - 1, 0);
                    run_len = 1;
                end
                last_low_cyc = cyc;
                last_low_idx = d;
            end else if (last_low_cyc == cyc - 1 && rst_) begin
                chk("drive_len", run_len, HOLD);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        bit found;
        rst_    = 1'b0;
        bus.req = '0;
        rq      = '0;

        drive(1'b0, '0);
        mon_en = 1'b1;
        drive(1'b0, '0);

        // Single request after reset
        drive(1'b1, 4'b0100);
        repeat (8) drive(1'b1, 4'b0000);

        // All requesting: strict rotation with no idle gaps
        repeat (20) drive(1'b1, 4'b1111);

        // Pointer wrap, then lone requester re-granted
        repeat (12) drive(1'b1, 4'b1001);
        repeat (12) drive(1'b1, 4'b1000);
        repeat (6) drive(1'b1, 4'b0000);

        // One-cycle pulse still completes the full transaction
        drive(1'b1, 4'b0010);
        repeat (8) drive(1'b1, 4'b0000);

        // Reset in the middle of a drive window
        drive(1'b1, 4'b0010);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.oe_ == 4'b1101) begin
                found = 1'b1;
                break;
            end
            drive(1'b1, 4'b0000);
        end
        chk("mid_drive_reached", found, 1);
        drive(1'b0, 4'b0000);
        repeat (10) drive(1'b1, 4'b1010);
        repeat (6) drive(1'b1, 4'b0000);

        // Randomized traffic with occasional resets
        repeat (4000) begin
            if ($urandom_range(0, 399) == 0) begin
                drive(1'b0, rq);
            end else begin
                if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
                drive(1'b1, rq);
            end
        end

        repeat (10) drive(1'b1, 4'b0000);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/am2918_bus_sched.md
# am2918_bus_sched

Round-robin scheduler that shares one three-state bus among N source registers of the am2918 type (D register with three-state output). For the selected source it first strobes the register load enable to capture that source's data, then enables its output driver for a fixed number of cycles. It then inserts one dead cycle before any other driver may turn on. It sits between the requesting microcode/datapath units and the bank of am2918 registers whose `y` outputs are wired together onto the shared bus.

## Interface
Parameters:
- `N`, 4: number of requesters/registers, 2..8.
- `HOLD`, 1: bus-drive cycles per grant, 1..255.
- `IW`, 2: width of `gidx`, equal to clog2(N) (min 1).

Ports:
- `cp`, input, 1: clock, rising edge; the only clock.
- `rst_`, input, 1: reset, synchronous, active-low.
- `req`, input, N: request per source; level-sensitive.
- `gnt`, output, N: one-hot grant, held for the whole transaction.
- `ld`, output, N: one-cycle load enable to source register i (gates its `cp`/enable).
- `oe_`, output, N: active-low output enables for the register bank; at most one low at any time.
- `gidx`, output, IW: index of current/last granted source.
- `busy`, output, 1: high in LOAD, DRIVE and TURN.
- `done`, output, 1: one-cycle pulse in TURN, marking the end of the transaction for `gidx`.

## Operation
- All outputs are registered (Moore). The states are IDLE, LOAD, DRIVE and TURN.
- Reset (`rst_`=0 at a rising edge) sets:
  - state to IDLE;
  - `gnt`, `ld` and `done` to 0, and `busy` to 0;
  - every bit of `oe_` to 1;
  - `gidx` to 0;
  - the priority pointer `ptr` to 0 and the hold counter to 0.
- Reset wins over every other event. This includes reset arriving mid-transaction: the bus is released at that edge.
- Arbitration (in IDLE and TURN):
  - The scheduler searches `req` starting at `ptr`, ascending modulo N. The first set bit i wins.
  - Next state is LOAD, with `gnt[i]`=1, `ld[i]`=1, `gidx`=i and `ptr` set to (i+1) mod N.
  - If no `req` bit is set, next state is IDLE.
- LOAD: lasts one cycle. `ld[i]`=1 and `oe_` is all ones. Next state is DRIVE, with the counter loaded to HOLD-1.
- DRIVE:
  - `oe_[i]`=0 and `ld`=0.
  - While the counter is not 0, decrement and stay in DRIVE. At 0, go to TURN.
  - DRIVE lasts exactly HOLD cycles.
- TURN:
  - `oe_` is all ones, `gnt` is 0 and `done`=1 for one cycle. `gidx` keeps i.
  - Arbitration runs here as well, so back-to-back grants need no IDLE cycle.
- `req` is sampled only during arbitration. A `req[i]` that drops during LOAD or DRIVE does not abort the transaction. A `req[i]` still high in TURN competes normally; the pointer has moved past i, so the other requesters are served first.
- Invariants:
  - `gnt` is one-hot or zero.
  - `ld` and `oe_`-low are never asserted in the same cycle.
  - No `oe_` is low in LOAD, TURN or IDLE.
  - `busy` = (state ≠ IDLE).

## Timing
- Request latency: `req[i]` high at edge k in IDLE gives:
  - `gnt[i]` and `ld[i]` from edge k+1 (LOAD);
  - `oe_[i]` low from edge k+2 through k+1+HOLD;
  - TURN/`done` at edge k+2+HOLD.
- Transaction length is HOLD+2 cycles. The back-to-back period is HOLD+2, because TURN overlaps arbitration.
- Data captured by `ld` at the end of LOAD is on the bus for all HOLD DRIVE cycles. A consumer samples the bus at the last DRIVE edge, or on the `done` edge from a register.
- Each requester with `req` held continuously is granted within N transactions (starvation-free).
- Counter width is clog2(HOLD), minimum 1. HOLD=1 gives a single DRIVE cycle.

## Test plan
- Reset then single request, with N=4 and HOLD=2:
  - Stimulus: `rst_`=0 for 2 cycles, then `req`=0100 at cycle 0.
  - Cycle 1: `gnt`=0100, `ld`=0100, `oe_`=1111.
  - Cycles 2–3: `oe_`=1011.
  - Cycle 4: `done`=1, `gidx`=2, `oe_`=1111.
  - Cycle 5: IDLE, `busy`=0.
- Round-robin fairness:
  - Stimulus: `req`=1111 held.
  - Grant order is 0,1,2,3,0, spaced 4 cycles apart, with no IDLE cycles and `done` pulsing every 4th cycle.
- Pointer behaviour:
  - Stimulus: after a grant to 3, `req`=1001.
  - The next grant is 0 (the pointer wraps), then 3.
  - With `req`=1000 held alone, 3 is re-granted every 4 cycles.
- Request drop:
  - Stimulus: `req[1]` pulsed for one cycle in IDLE.
  - The full LOAD/DRIVE/TURN sequence still completes for source 1, and `oe_[1]` is low for exactly HOLD cycles.
- Reset mid-DRIVE:
  - Stimulus: `rst_`=0 while `oe_`=1101.
  - At the next edge: `oe_`=1111, `gnt`=0, `busy`=0, and the pointer returns to 0.
  - After release, `req`=1010 grants 1 first.
- Bus-safety check (HOLD=1 and HOLD=5, random `req` for 10k cycles): the assertion must never fire:
  - at most one `oe_` bit is low;
  - no `ld` and `oe_`-low in the same cycle;
  - at least one all-ones `oe_` cycle between different drivers;
  - every granted source sees exactly HOLD low cycles.
